// File: rtl/core_if_prefetch_tag_buff_pkg.sv
// Shared types and helpers for the IF-stage tagged prefetch buffer.
// Entry layout and the address compare used by storage and lookup.
package core_if_buff_pkg;

  localparam int CORE_IF_ADDR_W = 32;
  localparam int CORE_IF_DATA_W = 32;

  typedef struct packed {
    logic                      valid;
    logic [CORE_IF_ADDR_W-1:0] addr;
    logic [CORE_IF_DATA_W-1:0] data;
  } entry_t;

  // Equal above the ignored low bits.
  function automatic logic addr_match(
    input logic [CORE_IF_ADDR_W-1:0] a,
    input logic [CORE_IF_ADDR_W-1:0] b,
    input int                        lsb_ign
  );
    logic [CORE_IF_ADDR_W-1:0] mask;
    mask = '1;
    mask = mask << lsb_ign;
    return ((a ^ b) & mask) == '0;
  endfunction

endpackage

// File: rtl/core_if_prefetch_tag_buff_if.sv
// Bus bundle between fetch logic and the prefetch tag buffer.
// master drives push/flush/inv/lookup, slave returns results.
interface core_if_prefetch_tag_buff_if
  import core_if_buff_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = CORE_IF_ADDR_W,
  parameter int DATA_W = CORE_IF_DATA_W
);

  logic                            write;
  logic [ADDR_W-1:0]               addr;
  logic [DATA_W-1:0]               data;
  logic                            flush;
  logic                            inv;
  logic [ADDR_W-1:0]               inv_addr;
  logic                            lookup;
  logic [ADDR_W-1:0]               lookup_addr;

  logic                            hit_valid;
  logic                            hit;
  logic [$clog2(DEPTH)-1:0]        hit_idx;
  logic [DATA_W-1:0]               hit_data;
  logic [$clog2(DEPTH+1)-1:0]      count;
  logic [DEPTH-1:0]                all_valid;
  logic [DEPTH-1:0][ADDR_W-1:0]    all_addr;
  logic [DEPTH-1:0][DATA_W-1:0]    all_data;

  modport master (
    output write, addr, data,
    output flush, inv, inv_addr,
    output lookup, lookup_addr,
    input  hit_valid, hit, hit_idx,
    input  hit_data, count,
    input  all_valid, all_addr, all_data
  );

  modport slave (
    input  write, addr, data,
    input  flush, inv, inv_addr,
    input  lookup, lookup_addr,
    output hit_valid, hit, hit_idx,
    output hit_data, count,
    output all_valid, all_addr, all_data
  );

endinterface

// File: rtl/core_if_prefetch_tag_buff_match.sv
// Lookup comparator over N candidate entries.
// Lowest matching index wins; outputs are zero on a miss.
module core_if_buff_match
  import core_if_buff_pkg::*;
#(
  parameter int N       = 4,
  parameter int LSB_IGN = 2
) (
  input  logic [CORE_IF_ADDR_W-1:0] key,
  input  entry_t [N-1:0]            cand,
  output logic                      match,
  output logic [$clog2(N)-1:0]      idx,
  output logic [CORE_IF_DATA_W-1:0] data
);

  localparam int IW = $clog2(N);

  // Scan from the top so the lowest hitting index is the last writer.
  always_comb begin
    match = 1'b0;
    idx   = '0;
    data  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i].valid &&
          addr_match(cand[i].addr, key, LSB_IGN)) begin
        match = 1'b1;
        idx   = IW'(i);
        data  = cand[i].data;
      end
    end
  end

endmodule

// File: rtl/core_if_prefetch_tag_buff.sv
// Tagged prefetch buffer for the IF stage: shift-in storage + lookup.
// Optional same-cycle write bypass: define CORE_IF_BUFF_BYPASS_EN.
module core_if_prefetch_tag_buff
  import core_if_buff_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = CORE_IF_ADDR_W,
  parameter int DATA_W  = CORE_IF_DATA_W,
  parameter int LSB_IGN = 2
) (
  input logic                        clk,
  input logic                        rest,
  core_if_prefetch_tag_buff_if.slave bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
`ifdef CORE_IF_BUFF_BYPASS_EN
  localparam int NC = DEPTH + 1;
`else
  localparam int NC = DEPTH;
`endif
  localparam int MW = $clog2(NC);

  logic [DEPTH-1:0]             vld_q;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [CW-1:0]                count_q;
  logic                         hit_valid_q;
  logic                         hit_q;
  logic [IW-1:0]                hit_idx_q;
  logic [DATA_W-1:0]            hit_data_q;

  entry_t [DEPTH-1:0]           cur;
  entry_t [DEPTH-1:0]           nxt;
  entry_t                       new_ent;
  logic [DEPTH-1:0]             nxt_vld;
  logic [CW-1:0]                cnt_d;
  logic [CORE_IF_ADDR_W-1:0]    inv_key;
  logic [CORE_IF_ADDR_W-1:0]    lk_key;

  entry_t [NC-1:0]              cand;
  logic                         m_hit;
  logic [MW-1:0]                m_idx;
  logic [CORE_IF_DATA_W-1:0]    m_data;
  logic [IW-1:0]                slot_idx;

  assign inv_key = CORE_IF_ADDR_W'(bus.inv_addr);
  assign lk_key  = CORE_IF_ADDR_W'(bus.lookup_addr);

  // Widen stored fields into package entries.
  always_comb begin
    new_ent.valid = 1'b1;
    new_ent.addr  = CORE_IF_ADDR_W'(bus.addr);
    new_ent.data  = CORE_IF_DATA_W'(bus.data);
    for (int i = 0; i < DEPTH; i++) begin
      cur[i].valid = vld_q[i];
      cur[i].addr  = CORE_IF_ADDR_W'(addr_q[i]);
      cur[i].data  = CORE_IF_DATA_W'(data_q[i]);
    end
  end

  // Post-edge storage: flush wins, else shift-in then invalidate old.
  always_comb begin
    nxt = cur;
    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        nxt[i].valid = 1'b0;
      end
    end else begin
      if (bus.write) begin
        for (int i = DEPTH - 1; i > 0; i--) begin
          nxt[i] = cur[i-1];
        end
        nxt[0] = new_ent;
      end
      if (bus.inv) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!(bus.write && i == 0) &&
              addr_match(nxt[i].addr, inv_key, LSB_IGN)) begin
            nxt[i].valid = 1'b0;
          end
        end
      end
    end
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      nxt_vld[i] = nxt[i].valid;
      cnt_d      = cnt_d + CW'(nxt[i].valid);
    end
  end

  // Lookup candidates: pre-edge slots, optionally fronted by the write.
  always_comb begin
`ifdef CORE_IF_BUFF_BYPASS_EN
    cand[0]       = new_ent;
    cand[0].valid = bus.write & ~bus.flush;
    for (int i = 0; i < DEPTH; i++) begin
      cand[i+1] = cur[i];
    end
`else
    cand = cur;
`endif
  end

  core_if_buff_match #(
    .N       (NC),
    .LSB_IGN (LSB_IGN)
  ) u_match (
    .key   (lk_key),
    .cand  (cand),
    .match (m_hit),
    .idx   (m_idx),
    .data  (m_data)
  );

  // Map candidate index back to slot index; bypass lands in slot 0.
  always_comb begin
`ifdef CORE_IF_BUFF_BYPASS_EN
    if (m_idx == '0) begin
      slot_idx = '0;
    end else begin
      slot_idx = IW'(m_idx - MW'(1));
    end
`else
    slot_idx = IW'(m_idx);
`endif
  end

  // Valid bits, occupancy and lookup result; async clear on reset.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      vld_q       <= '0;
      count_q     <= '0;
      hit_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      hit_data_q  <= '0;
    end else begin
      vld_q       <= nxt_vld;
      count_q     <= cnt_d;
      hit_valid_q <= bus.lookup;
      hit_q       <= bus.lookup & m_hit;
      hit_idx_q   <= (bus.lookup & m_hit) ? slot_idx : '0;
      hit_data_q  <= (bus.lookup & m_hit) ?
                     DATA_W'(m_data) : '0;
    end
  end

  // Address/data payload is never reset; stale values are harmless.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      addr_q[i] <= ADDR_W'(nxt[i].addr);
      data_q[i] <= DATA_W'(nxt[i].data);
    end
  end

  assign bus.hit_valid = hit_valid_q;
  assign bus.hit       = hit_q;
  assign bus.hit_idx   = hit_idx_q;
  assign bus.hit_data  = hit_data_q;
  assign bus.count     = count_q;
  assign bus.all_valid = vld_q;
  assign bus.all_addr  = addr_q;
  assign bus.all_data  = data_q;

endmodule

// File: doc/core_if_prefetch_tag_buff.md
# core_if_prefetch_tag_buff

Parametrised tagged prefetch buffer for the instruction-fetch stage, successor to the fixed 32-bit address/data shift buffer. It holds the last DEPTH fetched (address, data) pairs with explicit per-entry valid bits. It adds a registered address lookup (hit/data/index), flush, address invalidate and a live occupancy count. It sits between the fetch bus interface and the IF/ID pipeline register, and serves re-fetches after short backward branches without a bus access.

## Interface
- DEPTH, 4: number of entries, ≥2.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- LSB_IGN, 2: low address bits ignored in every compare.
- clk  in  1  clock, all state updates on rising edge.
- rest  in  1  reset, asynchronous, active-high.
- write  in  1  push new pair into slot 0, shifting older entries toward slot DEPTH-1.
- addr  in  ADDR_W  address to push.
- data  in  DATA_W  data to push.
- flush  in  1  clear all valid bits.
- inv  in  1  invalidate every entry whose address matches inv_addr.
- inv_addr  in  ADDR_W  invalidate address.
- lookup  in  1  lookup request.
- lookup_addr  in  ADDR_W  lookup address.
- hit_valid  out  1  registered: a lookup was issued last cycle.
- hit  out  1  registered: that lookup matched a valid entry.
- hit_idx  out  $clog2(DEPTH)  registered: slot index of the match.
- hit_data  out  DATA_W  registered: data of the match.
- count  out  $clog2(DEPTH+1)  number of valid entries.
- all_valid  out  DEPTH  per-slot valid bits.
- all_addr  out  [DEPTH-1:0][ADDR_W]  per-slot addresses, combinational from storage.
- all_data  out  [DEPTH-1:0][DATA_W]  per-slot data, combinational from storage.

## Operation
- Storage: DEPTH slots of {valid, addr, data}. Slot 0 is newest.
- Compare: two addresses match when bits [ADDR_W-1:LSB_IGN] are equal.
- Priority per edge: rest > flush > write/inv.
- flush: all valid bits go to 0. A same-cycle write is dropped. A same-cycle inv is irrelevant.
- write without flush: slot0 ← {1, addr, data} and slot i ← slot i-1. The entry in slot DEPTH-1 is discarded.
- inv: clears valid on matching entries after the shift is applied, only for entries that came from old slots. A same-cycle written entry stays valid even if its address matches inv_addr.
- Lookup:
  - Compares lookup_addr against all valid slots using pre-edge state.
  - The lowest index wins, which is the newest entry.
  - The result is registered into hit/hit_idx/hit_data with hit_valid=1.
  - When hit=0, hit_idx=0 and hit_data=0.
  - A lookup in the same cycle as flush or inv still sees pre-edge contents.
- count: a register equal to the popcount of the post-edge valid bits. It saturates naturally at DEPTH; the 0..DEPTH range needs no wrap.
- all_addr/all_data show stored fields regardless of valid. Invalid slots keep stale addr/data.

## Timing
- Reset values: all valid=0, count=0, hit_valid=0, hit=0, hit_idx=0, hit_data=0. Addr/data storage is not reset.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge.
- Write-to-visibility: one edge. An entry written at edge N is visible to a lookup presented in cycle N+1, with its result at edge N+2.
- Lookup latency: 1 cycle.
- No backpressure. Lookups may be issued every cycle, and hit_valid follows lookup delayed by one cycle.
- Flush/inv take effect at the edge where they are sampled.

## Configuration
- CORE_IF_BUFF_BYPASS_EN defined:
  - The lookup also compares against the same-cycle write {addr, data}.
  - A match there takes highest priority, reported as hit_idx=0, because the entry lands in slot 0.
  - When flush is also high, the bypass is suppressed.
- CORE_IF_BUFF_BYPASS_EN undefined: the lookup sees only pre-edge storage, as described in Operation.

## Structure
- Package core_if_buff_pkg holds:
  - the entry struct typedef (valid, addr, data), parametrised via package localparams CORE_IF_ADDR_W and CORE_IF_DATA_W;
  - a function addr_match(a, b, lsb_ign).
- Sub-module core_if_buff_match: combinational compare of the lookup address against DEPTH (+1 with bypass) candidates, plus a lowest-index priority encoder. It outputs match, idx and data.

## Test plan
- Reset, then write 0x100/0xA, 0x104/0xB, 0x108/0xC → count=3, all_valid=0b0111, all_addr[0]=0x108.
- Lookup 0x104 → next cycle hit_valid=1, hit=1, hit_idx=1, hit_data=0xB. Lookup 0x200 → hit=0, hit_data=0.
- DEPTH=4: write 5 entries 0x0..0x10 → 0x0 evicted; lookup 0x0 misses; count=4.
- Write 0x100/0x1, then 0x100/0x2 → lookup 0x102 hits idx 0 with data 0x2 (newest wins, LSBs ignored).
- inv 0x100 together with write 0x100/0x3 → slot0 valid with data 0x3, older 0x100 entries invalid.
- flush together with write → count=0, all_valid=0. rest pulsed between edges clears hit and count asynchronously.
- With CORE_IF_BUFF_BYPASS_EN: lookup 0x300 in the same cycle as write 0x300/0xD → next cycle hit=1, idx=0, data=0xD. Without the macro → hit=0.
